// File: rtl/trap_collector.sv
// rtl/trap_collector.sv - keeps the oldest reported exception and hands it to commit at the ROB head
module trap_collector #(
    parameter int NUM_REPORT = 4,
    parameter int ROB_SIZE   = 96,
    parameter int CAUSE_W    = 16,
    parameter int TVAL_W     = 64,
    localparam int IDX_W     = $clog2(ROB_SIZE),
    localparam int RID_W     = IDX_W + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REPORT-1:0]                i_rpt_vld,
    input  logic [NUM_REPORT-1:0][RID_W-1:0]     i_rpt_robIdx,
    input  logic [NUM_REPORT-1:0][CAUSE_W-1:0]   i_rpt_cause,
    input  logic [NUM_REPORT-1:0][TVAL_W-1:0]    i_rpt_tval,
    input  logic                                 i_squash_vld,
    input  logic [RID_W-1:0]                     i_squash_robIdx,
    input  logic                                 i_flush,
    input  logic [RID_W-1:0]                     i_rob_head,
    output logic                                 o_trap_vld,
    output logic [RID_W-1:0]                     o_trap_robIdx,
    output logic [CAUSE_W-1:0]                   o_trap_cause,
    output logic [TVAL_W-1:0]                    o_trap_tval,
    input  logic                                 i_trap_ack,
    output logic                                 o_pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]         r_state;
    logic               r_trap_vld;
    logic [RID_W-1:0]   r_robIdx;
    logic [CAUSE_W-1:0] r_cause;
    logic [TVAL_W-1:0]  r_tval;

    logic               w_sel_vld;
    logic [RID_W-1:0]   w_sel_robIdx;
    logic [CAUSE_W-1:0] w_sel_cause;
    logic [TVAL_W-1:0]  w_sel_tval;
    logic               w_held_killed;
    logic               w_sel_older;
    logic               w_head_hit;
    logic               w_load;
    logic               w_clear;
    logic [1:0]         w_state_nxt;
    logic               w_vld_nxt;

    // Flipped bit distinguishes ROB laps, so the idx order inverts across the wrap.
    function automatic logic is_older(input logic [RID_W-1:0] a, input logic [RID_W-1:0] b);
        if (a[RID_W-1] == b[RID_W-1]) begin
            return a[IDX_W-1:0] < b[IDX_W-1:0];
        end
        return a[IDX_W-1:0] > b[IDX_W-1:0];
    endfunction

    // Strictly-older test keeps the lowest port on robIdx ties; squashed reports never compete.
    always_comb begin
        w_sel_vld    = 1'b0;
        w_sel_robIdx = '0;
        w_sel_cause  = '0;
        w_sel_tval   = '0;
        for (int p = 0; p < NUM_REPORT; p++) begin
            if (i_rpt_vld[p]
                && !(i_squash_vld && is_older(i_squash_robIdx, i_rpt_robIdx[p]))
                && (!w_sel_vld || is_older(i_rpt_robIdx[p], w_sel_robIdx))) begin
                w_sel_vld    = 1'b1;
                w_sel_robIdx = i_rpt_robIdx[p];
                w_sel_cause  = i_rpt_cause[p];
                w_sel_tval   = i_rpt_tval[p];
            end
        end
    end

    assign w_held_killed = i_squash_vld && is_older(i_squash_robIdx, r_robIdx);
    assign w_sel_older   = w_sel_vld && is_older(w_sel_robIdx, r_robIdx);
    assign w_head_hit    = (r_robIdx == i_rob_head);

    always_comb begin
        w_state_nxt = r_state;
        w_vld_nxt   = r_trap_vld;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_vld_nxt   = 1'b0;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_vld) begin
                        w_state_nxt = HELD;
                        w_load      = 1'b1;
                    end
                end
                HELD: begin
                    if (w_held_killed && !w_sel_vld) begin
                        w_state_nxt = IDLE;
                        w_clear     = 1'b1;
                    end else if (w_held_killed || w_sel_older) begin
                        // A fresh capture defers the head match to the next cycle.
                        w_load      = 1'b1;
                    end else if (w_head_hit) begin
                        w_state_nxt = WAIT;
                        w_vld_nxt   = 1'b1;
                    end
                end
                WAIT: begin
                    if (r_trap_vld && i_trap_ack) begin
                        w_state_nxt = IDLE;
                        w_vld_nxt   = 1'b0;
                        w_clear     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_vld_nxt   = 1'b0;
                    w_clear     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_trap_vld <= 1'b0;
            r_robIdx   <= '0;
            r_cause    <= '0;
            r_tval     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_trap_vld <= w_vld_nxt;
            if (w_clear) begin
                r_robIdx <= '0;
                r_cause  <= '0;
                r_tval   <= '0;
            end else if (w_load) begin
                r_robIdx <= w_sel_robIdx;
                r_cause  <= w_sel_cause;
                r_tval   <= w_sel_tval;
            end
        end
    end

    assign o_trap_vld    = r_trap_vld;
    assign o_trap_robIdx = r_robIdx;
    assign o_trap_cause  = r_cause;
    assign o_trap_tval   = r_tval;
    assign o_pending     = (r_state != IDLE);

endmodule

// File: tb/tb_trap_collector.sv
// tb/tb_trap_collector.sv - directed vector bench for trap_collector
module tb_trap_collector;

    localparam logic [7:0] Z  = 8'h00;
    localparam logic [7:0] NH = 8'hFF;

    typedef struct {
        string             name;
        logic              rst;
        logic [3:0]        vld;
        logic [3:0][7:0]   rob;
        logic [3:0][15:0]  cause;
        logic              sq;
        logic [7:0]        sq_rob;
        logic              fl;
        logic [7:0]        head;
        logic              ack;
        logic              e_vld;
        logic              e_pend;
        logic [7:0]        e_rob;
        logic [15:0]       e_cause;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       rpt_vld;
    logic [3:0][7:0]  rpt_rob;
    logic [3:0][15:0] rpt_cause;
    logic [3:0][63:0] rpt_tval;
    logic             squash_vld;
    logic [7:0]       squash_rob;
    logic             flush;
    logic [7:0]       rob_head;
    logic             trap_vld;
    logic [7:0]       trap_rob;
    logic [15:0]      trap_cause;
    logic [63:0]      trap_tval;
    logic             trap_ack;
    logic             pending;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    trap_collector dut (
        .clk             (clk),
        .rst             (rst),
        .i_rpt_vld       (rpt_vld),
        .i_rpt_robIdx    (rpt_rob),
        .i_rpt_cause     (rpt_cause),
        .i_rpt_tval      (rpt_tval),
        .i_squash_vld    (squash_vld),
        .i_squash_robIdx (squash_rob),
        .i_flush         (flush),
        .i_rob_head      (rob_head),
        .o_trap_vld      (trap_vld),
        .o_trap_robIdx   (trap_rob),
        .o_trap_cause    (trap_cause),
        .o_trap_tval     (trap_tval),
        .i_trap_ack      (trap_ack),
        .o_pending       (pending)
    );

    function automatic logic [7:0] R(input logic f, input int i);
        return {f, 7'(i)};
    endfunction

    function automatic logic [63:0] tv(input logic [7:0] r, input logic [15:0] c);
        return {40'hCAFE000000, c, r};
    endfunction

    task automatic add(input string n, input logic rs, input logic [3:0] v, input logic [31:0] rb,
                       input logic [63:0] cs, input logic sq, input logic [7:0] sqr, input logic fl,
                       input logic [7:0] hd, input logic ak, input logic ev, input logic ep,
                       input logic [7:0] er, input logic [15:0] ec);
        vec_t x;
        x.name = n; x.rst = rs; x.vld = v; x.rob = rb; x.cause = cs;
        x.sq = sq; x.sq_rob = sqr; x.fl = fl; x.head = hd; x.ack = ak;
        x.e_vld = ev; x.e_pend = ep; x.e_rob = er; x.e_cause = ec;
        vecs.push_back(x);
    endtask

    task automatic clr_in();
        rst = 1'b1; rpt_vld = '0; rpt_rob = '0; rpt_cause = '0; rpt_tval = '0;
        squash_vld = 1'b0; squash_rob = '0; flush = 1'b0; rob_head = NH; trap_ack = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [7:0] r, input logic [15:0] c);
        rpt_vld[p] = 1'b1; rpt_rob[p] = r; rpt_cause[p] = c; rpt_tval[p] = tv(r, c);
    endtask

    task automatic chk(input string n, input logic ev, input logic ep, input logic [7:0] er,
                       input logic [15:0] ec);
        logic [63:0] et;
        et = ep ? tv(er, ec) : 64'd0;
        total++;
        if (trap_vld !== ev || pending !== ep || trap_rob !== er || trap_cause !== ec || trap_tval !== et) begin
            bad++;
            $display("FAIL %s: got vld=%0b pend=%0b rob=%h cause=%0d tval=%h, want vld=%0b pend=%0b rob=%h cause=%0d tval=%h",
                     n, trap_vld, pending, trap_rob, trap_cause, trap_tval, ev, ep, er, ec, et);
        end
    endtask

    task automatic step(input string n, input logic ev, input logic ep, input logic [7:0] er,
                        input logic [15:0] ec);
        @(posedge clk);
        #1;
        chk(n, ev, ep, er, ec);
    endtask

    initial begin
        clr_in();
        rst = 1'b0;

        add("reset",        0, 4'b0000, 32'd0, 64'd0, 0, Z, 0, NH, 0,  0, 0, Z, 16'd0);
        add("idle",         1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, NH, 0,  0, 0, Z, 16'd0);
        add("t1_capture",   1, 4'b0001, {Z, Z, Z, R(0,5)}, {16'd0, 16'd0, 16'd0, 16'd2}, 0, Z, 0, NH, 0,  0, 1, R(0,5), 16'd2);
        add("t1_headhit",   1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,5), 0,  1, 1, R(0,5), 16'd2);
        add("t1_wait_hold", 1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,5), 0,  1, 1, R(0,5), 16'd2);
        add("t1_ack",       1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,5), 1,  0, 0, Z, 16'd0);
        add("t1_idle",      1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, NH, 0,  0, 0, Z, 16'd0);
        add("t2_arb_tie",   1, 4'b1110, {R(0,3), R(0,3), R(0,9), Z}, {16'd7, 16'd13, 16'd5, 16'd0}, 0, Z, 0, NH, 0,  0, 1, R(0,3), 16'd13);
        add("t2_equal_ign", 1, 4'b0001, {Z, Z, Z, R(0,3)}, {16'd0, 16'd0, 16'd0, 16'd9}, 0, Z, 0, NH, 0,  0, 1, R(0,3), 16'd13);
        add("t2_cap_match", 1, 4'b0001, {Z, Z, Z, R(0,1)}, {16'd0, 16'd0, 16'd0, 16'd6}, 0, Z, 0, R(0,3), 0,  0, 1, R(0,1), 16'd6);
        add("t2_headhit",   1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,1), 0,  1, 1, R(0,1), 16'd6);
        add("t2_wait_ign",  1, 4'b0010, {Z, Z, R(0,0), Z}, {16'd0, 16'd0, 16'd3, 16'd0}, 0, Z, 0, R(0,1), 0,  1, 1, R(0,1), 16'd6);
        add("t2_ack",       1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,1), 1,  0, 0, Z, 16'd0);
        add("t3_hold94",    1, 4'b0001, {Z, Z, Z, R(0,94)}, {16'd0, 16'd0, 16'd0, 16'd4}, 0, Z, 0, NH, 0,  0, 1, R(0,94), 16'd4);
        add("t3_wrap_ign",  1, 4'b0010, {Z, Z, R(1,2), Z}, {16'd0, 16'd0, 16'd1, 16'd0}, 0, Z, 0, NH, 0,  0, 1, R(0,94), 16'd4);
        add("t3_older90",   1, 4'b0100, {Z, R(0,90), Z, Z}, {16'd0, 16'd12, 16'd0, 16'd0}, 0, Z, 0, NH, 0,  0, 1, R(0,90), 16'd12);
        add("t3_flush",     1, 4'b0000, 32'd0, 64'd0, 0, Z, 1, NH, 0,  0, 0, Z, 16'd0);
        add("t3_hold_f1",   1, 4'b1000, {R(1,2), Z, Z, Z}, {16'd1, 16'd0, 16'd0, 16'd0}, 0, Z, 0, NH, 0,  0, 1, R(1,2), 16'd1);
        add("t3_wrap_old",  1, 4'b0001, {Z, Z, Z, R(0,94)}, {16'd0, 16'd0, 16'd0, 16'd4}, 0, Z, 0, NH, 0,  0, 1, R(0,94), 16'd4);
        add("t3_flush2",    1, 4'b0000, 32'd0, 64'd0, 0, Z, 1, NH, 0,  0, 0, Z, 16'd0);
        add("t4_hold40",    1, 4'b0001, {Z, Z, Z, R(0,40)}, {16'd0, 16'd0, 16'd0, 16'd3}, 0, Z, 0, NH, 0,  0, 1, R(0,40), 16'd3);
        add("t4_sq_cap20",  1, 4'b0110, {Z, R(0,35), R(0,20), Z}, {16'd0, 16'd11, 16'd8, 16'd0}, 1, R(0,30), 0, NH, 0,  0, 1, R(0,20), 16'd8);
        add("t4_sq_surv",   1, 4'b0000, 32'd0, 64'd0, 1, R(0,25), 0, NH, 0,  0, 1, R(0,20), 16'd8);
        add("t4_sq_kill",   1, 4'b0000, 32'd0, 64'd0, 1, R(0,10), 0, NH, 0,  0, 0, Z, 16'd0);
        add("t4_hold50",    1, 4'b0001, {Z, Z, Z, R(0,50)}, {16'd0, 16'd0, 16'd0, 16'd5}, 0, Z, 0, NH, 0,  0, 1, R(0,50), 16'd5);
        add("t4_sq_both",   1, 4'b0010, {Z, Z, R(0,47), Z}, {16'd0, 16'd0, 16'd2, 16'd0}, 1, R(0,45), 0, NH, 0,  0, 0, Z, 16'd0);
        add("t4_hold60",    1, 4'b0001, {Z, Z, Z, R(0,60)}, {16'd0, 16'd0, 16'd0, 16'd7}, 0, Z, 0, NH, 0,  0, 1, R(0,60), 16'd7);
        add("t4_sq_equal",  1, 4'b0000, 32'd0, 64'd0, 1, R(0,60), 0, NH, 0,  0, 1, R(0,60), 16'd7);
        add("t4_flush",     1, 4'b0000, 32'd0, 64'd0, 0, Z, 1, NH, 0,  0, 0, Z, 16'd0);
        add("t5_hold70",    1, 4'b0001, {Z, Z, Z, R(0,70)}, {16'd0, 16'd0, 16'd0, 16'd2}, 0, Z, 0, NH, 0,  0, 1, R(0,70), 16'd2);
        add("t5_ack_held",  1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, NH, 1,  0, 1, R(0,70), 16'd2);
        add("t5_headhit",   1, 4'b0000, 32'd0, 64'd0, 0, Z, 0, R(0,70), 0,  1, 1, R(0,70), 16'd2);

        foreach (vecs[k]) begin
            rst        = vecs[k].rst;
            rpt_vld    = vecs[k].vld;
            rpt_rob    = vecs[k].rob;
            rpt_cause  = vecs[k].cause;
            for (int p = 0; p < 4; p++) rpt_tval[p] = tv(vecs[k].rob[p], vecs[k].cause[p]);
            squash_vld = vecs[k].sq;
            squash_rob = vecs[k].sq_rob;
            flush      = vecs[k].fl;
            rob_head   = vecs[k].head;
            trap_ack   = vecs[k].ack;
            step(vecs[k].name, vecs[k].e_vld, vecs[k].e_pend, vecs[k].e_rob, vecs[k].e_cause);
        end

        // Flush while in WAIT with a same-cycle report and a pending ack.
        clr_in(); rob_head = R(0,70); flush = 1'b1; trap_ack = 1'b1; set_port(2, R(0,0), 16'd9);
        step("flush_wait", 0, 0, Z, 16'd0);
        clr_in();
        step("flush_after", 0, 0, Z, 16'd0);

        // Reset asserted while in WAIT, then normal capture resumes.
        clr_in(); set_port(0, R(0,8), 16'd5);
        step("rst_seq_cap", 0, 1, R(0,8), 16'd5);
        clr_in(); rob_head = R(0,8);
        step("rst_seq_wait", 1, 1, R(0,8), 16'd5);
        clr_in(); rst = 1'b0; rob_head = R(0,8); set_port(1, R(0,2), 16'd3);
        step("rst_in_wait", 0, 0, Z, 16'd0);
        clr_in(); set_port(0, R(0,1), 16'd2);
        step("rst_recap", 0, 1, R(0,1), 16'd2);
        clr_in(); rob_head = R(0,1);
        step("rst_rehit", 1, 1, R(0,1), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trap_collector.md
Name: trap_collector

Overview:
- Receives exception reports from the execute/LSU writeback ports and keeps only the oldest one in program order.
- Each report is tagged with a robIdx_t (flipped bit + index) and a 16-bit rv_trap_t::exception mcause code.
- Presents the held exception to commit once its robIdx equals the ROB head, then waits for commit's acknowledge.
- Sits between the writeback ports and the ROB commit/CSR trap logic.

Parameters:
NUM_REPORT, 4, number of exception report ports
ROB_SIZE, 96, ROB depth; idx width = $clog2(ROB_SIZE) = 7, robIdx_t width = 8
CAUSE_W, 16, width of the mcause code
TVAL_W, 64, width of the trap value (XLEN)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-low reset
i_rpt_vld  in  NUM_REPORT  per-port report valid
i_rpt_robIdx  in  NUM_REPORT x 8  robIdx_t of the faulting instruction
i_rpt_cause  in  NUM_REPORT x 16  exception code
i_rpt_tval  in  NUM_REPORT x 64  faulting address or instruction bits
i_squash_vld  in  1  misprediction squash
i_squash_robIdx  in  8  squash point; entries strictly younger are killed
i_flush  in  1  full pipeline flush (trap taken or redirect)
i_rob_head  in  8  robIdx_t of the oldest uncommitted instruction
o_trap_vld  out  1  held exception is at the ROB head
o_trap_robIdx  out  8  robIdx of the held exception
o_trap_cause  out  16  held exception code
o_trap_tval  out  64  held trap value
i_trap_ack  in  1  commit has consumed the trap
o_pending  out  1  an exception is held; commit stops retiring past it

Behaviour:
- Age rule: older(a,b) = (a.flipped==b.flipped) ? (a.idx<b.idx) : (a.idx>b.idx). Equal robIdx is not older.
- Reset (rst==0 at posedge): state=IDLE. o_trap_vld=0, o_pending=0, o_trap_robIdx=0, o_trap_cause=0, o_trap_tval=0. Reset mid-operation drops any held exception.
- Port selection, combinational: among valid ports, pick the oldest; on equal robIdx the lowest port number wins.
- States:
  - IDLE: a valid selected report is captured at the clock edge; go to HELD.
  - HELD: a selected report older than the held one replaces it; an equal or younger report is ignored. If the held robIdx == i_rob_head, go to WAIT, or stay in HELD when capture and match happen in the same cycle.
  - WAIT: o_trap_vld=1. Captured content is frozen; later reports are ignored because nothing can be older than the head. On i_trap_ack, go to IDLE and clear outputs the next cycle.
- o_trap_vld is registered and asserts the cycle after the head match is seen in HELD. It stays high until ack; ack is sampled only when o_trap_vld=1.
- o_pending=1 in HELD and WAIT.
- Squash, in HELD only: if the held robIdx is strictly younger than i_squash_robIdx, go to IDLE. In the same cycle, new reports that are not younger than the squash point may still be captured; younger reports are discarded.
- Flush: highest priority. Go to IDLE at the next edge, drop new reports in that cycle, and override ack/squash/capture.
- Wrap-around: the flipped-bit comparison must hold across idx 95 -> 0.
- No backpressure on report ports: every report is consumed or dropped in the cycle it is presented.

Test Plan:
- Single report: port0 robIdx={0,5}, cause=2 (instIllegal), head={0,5} -> captured, o_pending=1; o_trap_vld=1 with cause=2 one cycle later; ack -> all outputs 0 next cycle.
- Same-cycle arbitration: port1 {0,9} cause 5, port2 {0,3} cause 13, port3 {0,3} cause 7 -> held robIdx {0,3}, cause 13 (port2 beats port3 on tie).
- Wrap age: held {0,94} cause 4, then report {1,2} cause 1 -> held stays {0,94}; then report {0,90} cause 12 -> replaced by {0,90}.
- Squash: held {0,40}, squash robIdx {0,30}, same-cycle report {0,20} cause 8 -> held becomes {0,20} cause 8; squash {0,10} in a later cycle -> IDLE, o_pending=0.
- Flush with same-cycle report and pending ack in WAIT -> IDLE next cycle, nothing captured, o_trap_vld=0.
- Reset asserted in WAIT (rst=0 for one edge) -> every output 0 next cycle; report {0,1} afterwards is captured normally.
